// File: rtl/spram_arbiter.sv
`default_nettype none
// ============================================================================
// spram_arbiter : PS-priority / round-robin PL arbiter for one BRAM port
// Rev 1.0
// ============================================================================
module spram_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic                          clka,
  input  logic                          rsta,
  input  logic                          ps_en,
  input  logic [DATA_W/8-1:0]           ps_we,
  input  logic [ADDR_W-1:0]             ps_addr,
  input  logic [DATA_W-1:0]             ps_din,
  output logic [DATA_W-1:0]             ps_dout,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          bram_en,
  output logic [DATA_W/8-1:0]           bram_we,
  output logic [ADDR_W-1:0]             bram_addr,
  output logic [DATA_W-1:0]             bram_din,
  input  logic [DATA_W-1:0]             bram_dout
);

  localparam int c_BE_W  = DATA_W / 8;
  localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [c_IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [READ_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [c_IDX_W-1:0]  tag_idx_q [READ_LAT];
  logic [c_IDX_W-1:0]  tag_idx_d [READ_LAT];

  logic                grant_found;
  logic [c_IDX_W-1:0]  grant_idx;
  logic                pl_accept;
  logic                pl_read;
  int                  cand;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req_valid[c_IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = c_IDX_W'(cand);
      end
    end
  end

  // Port mux: reset blocks everyone, then PS, then the granted PL requester.
  always_comb begin
    bram_en   = 1'b0;
    bram_we   = '0;
    bram_addr = '0;
    bram_din  = '0;
    req_ready = '0;
    pl_accept = 1'b0;
    pl_read   = 1'b0;
    if (!rsta) begin
      if (ps_en) begin
        bram_en   = 1'b1;
        bram_we   = ps_we;
        bram_addr = ps_addr;
        bram_din  = ps_din;
      end else if (grant_found) begin
        bram_en              = 1'b1;
        bram_we              = req_we[grant_idx*c_BE_W +: c_BE_W];
        bram_addr            = req_addr[grant_idx*ADDR_W +: ADDR_W];
        bram_din             = req_wdata[grant_idx*DATA_W +: DATA_W];
        req_ready[grant_idx] = 1'b1;
        pl_accept            = 1'b1;
        pl_read              = (req_we[grant_idx*c_BE_W +: c_BE_W] == '0);
      end
    end
  end

  // The tag pipe shifts every cycle so PS traffic never stalls in-flight reads.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (pl_accept) begin
      rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + c_IDX_W'(1);
    end
    tag_vld_d    = '0;
    tag_vld_d[0] = pl_accept & pl_read;
    tag_idx_d[0] = grant_idx;
    for (int s = 1; s < READ_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      rr_ptr_q  <= '0;
      tag_vld_q <= '0;
      for (int s = 0; s < READ_LAT; s++) tag_idx_q[s] <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      tag_vld_q <= tag_vld_d;
      for (int s = 0; s < READ_LAT; s++) tag_idx_q[s] <= tag_idx_d[s];
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (!rsta && tag_vld_q[READ_LAT-1]) rsp_valid[tag_idx_q[READ_LAT-1]] = 1'b1;
  end

  assign rsp_rdata = bram_dout;
  assign ps_dout   = bram_dout;

endmodule
`default_nettype wire

// File: tb/tb_spram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_spram_arbiter : randomized check of spram_arbiter (READ_LAT 1 and 2)
// Rev 1.0
// ============================================================================
module tb_spram_arbiter;

  localparam int NR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, ps_en;
  logic [3:0]      ps_we;
  logic [12:0]     ps_addr;
  logic [31:0]     ps_din;
  logic [NR-1:0]   req_valid;
  logic [NR*4-1:0] req_we;
  logic [NR*13-1:0] req_addr;
  logic [NR*32-1:0] req_wdata;

  logic [NR-1:0] a_rdy, a_rspv, b_rdy, b_rspv;
  logic [31:0]   a_rdata, a_psdout, a_din, a_dout, b_rdata, b_psdout, b_din, b_dout;
  logic          a_en, b_en;
  logic [3:0]    a_we, b_we;
  logic [12:0]   a_addr, b_addr;

  spram_arbiter #(.NUM_REQ(NR), .ADDR_W(13), .DATA_W(32), .READ_LAT(1)) u_dut_a (
    .clka(clk), .rsta(rst), .ps_en(ps_en), .ps_we(ps_we), .ps_addr(ps_addr),
    .ps_din(ps_din), .ps_dout(a_psdout), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(a_rdy),
    .rsp_valid(a_rspv), .rsp_rdata(a_rdata), .bram_en(a_en), .bram_we(a_we),
    .bram_addr(a_addr), .bram_din(a_din), .bram_dout(a_dout));

  spram_arbiter #(.NUM_REQ(NR), .ADDR_W(13), .DATA_W(32), .READ_LAT(2)) u_dut_b (
    .clka(clk), .rsta(rst), .ps_en(ps_en), .ps_we(ps_we), .ps_addr(ps_addr),
    .ps_din(ps_din), .ps_dout(b_psdout), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(b_rdy),
    .rsp_valid(b_rspv), .rsp_rdata(b_rdata), .bram_en(b_en), .bram_we(b_we),
    .bram_addr(b_addr), .bram_din(b_din), .bram_dout(b_dout));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] we);
    logic [31:0] w;
    w = old;
    for (int i = 0; i < 4; i++) if (we[i]) w[i*8 +: 8] = din[i*8 +: 8];
    return w;
  endfunction

  // Write-first BRAM models, latency 1 and 2.
  logic [31:0] mem_a [8192];
  logic [31:0] mem_b [8192];
  logic [31:0] a_q1, b_q1, b_q2;
  always @(posedge clk) begin
    if (a_en) begin
      mem_a[a_addr] <= merge(mem_a[a_addr], a_din, a_we);
      a_q1          <= merge(mem_a[a_addr], a_din, a_we);
    end
    if (b_en) begin
      mem_b[b_addr] <= merge(mem_b[b_addr], b_din, b_we);
      b_q1          <= merge(mem_b[b_addr], b_din, b_we);
    end
    b_q2 <= b_q1;
  end
  assign a_dout = a_q1;
  assign b_dout = b_q2;

  // ---------------- reference model ----------------
  typedef struct { int due; int idx; logic [31:0] data; } rsp_t;
  typedef struct { int due; logic [31:0] data; } psr_t;
  rsp_t qa[$];
  rsp_t qb[$];
  psr_t pa[$];
  psr_t pb[$];
  logic [31:0] ref_mem [8192];
  int rr, cyc, last_grant;
  int n_cmp, n_err;

  // staged stimulus, applied at the next falling edge
  logic        n_rst, n_ps_en;
  logic [3:0]  n_ps_we;
  logic [12:0] n_ps_addr;
  logic [31:0] n_ps_din;
  logic        pv    [NR];
  logic [3:0]  pwe   [NR];
  logic [12:0] paddr [NR];
  logic [31:0] pdata [NR];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] we, input logic [12:0] ad,
                         input logic [31:0] d);
    pv[i] = 1'b1; pwe[i] = we; paddr[i] = ad; pdata[i] = d;
  endtask

  task automatic check_rsp(input string tag, input logic [NR-1:0] vobs,
                           input logic [31:0] dobs, inout rsp_t q[$]);
    logic [NR-1:0] vexp;
    vexp = '0;
    if (!rst && q.size() > 0 && q[0].due == cyc) vexp[q[0].idx] = 1'b1;
    check_eq({tag, "_rsp_valid"}, 32'(vobs), 32'(vexp));
    if (vexp != '0) check_eq({tag, "_rsp_rdata"}, dobs, q[0].data);
    while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
  endtask

  task automatic check_ps(input string tag, input logic [31:0] dobs, inout psr_t q[$]);
    if (q.size() > 0 && q[0].due == cyc) check_eq({tag, "_ps_dout"}, dobs, q[0].data);
    while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
  endtask

  task automatic cycle();
    int g, c;
    logic [NR-1:0] exp_rdy;
    logic exp_en;
    logic [12:0] ad;
    logic [3:0] we;
    logic [31:0] w;
    @(negedge clk);
    rst = n_rst; ps_en = n_ps_en; ps_we = n_ps_we; ps_addr = n_ps_addr; ps_din = n_ps_din;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = pv[i];
      req_we[i*4 +: 4]      = pwe[i];
      req_addr[i*13 +: 13]  = paddr[i];
      req_wdata[i*32 +: 32] = pdata[i];
    end
    #1;
    g = -1;
    if (!rst && !ps_en)
      for (int k = 0; k < NR; k++) begin
        c = (rr + k) % NR;
        if (g < 0 && req_valid[c]) g = c;
      end
    exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
    exp_en  = !rst && (ps_en || g >= 0);
    check_eq("a_req_ready", 32'(a_rdy), 32'(exp_rdy));
    check_eq("b_req_ready", 32'(b_rdy), 32'(exp_rdy));
    check_eq("a_bram_en", 32'(a_en), 32'(exp_en));
    check_eq("b_bram_en", 32'(b_en), 32'(exp_en));
    if (g >= 0) check_eq("a_bram_addr", 32'(a_addr), 32'(req_addr[g*13 +: 13]));
    check_rsp("a", a_rspv, a_rdata, qa);
    check_rsp("b", b_rspv, b_rdata, qb);
    check_ps("a", a_psdout, pa);
    check_ps("b", b_psdout, pb);
    if (rst) begin
      qa.delete(); qb.delete(); pa.delete(); pb.delete();
      rr = 0;
    end else if (ps_en) begin
      w = merge(ref_mem[ps_addr], ps_din, ps_we);
      ref_mem[ps_addr] = w;
      if (ps_we == 4'h0) begin
        pa.push_back('{due: cyc + 1, data: w});
        pb.push_back('{due: cyc + 2, data: w});
      end
    end else if (g >= 0) begin
      ad = req_addr[g*13 +: 13];
      we = req_we[g*4 +: 4];
      if (we != 4'h0) ref_mem[ad] = merge(ref_mem[ad], req_wdata[g*32 +: 32], we);
      else begin
        qa.push_back('{due: cyc + 1, idx: g, data: ref_mem[ad]});
        qb.push_back('{due: cyc + 2, idx: g, data: ref_mem[ad]});
      end
      rr = (g + 1) % NR;
      pv[g] = 1'b0;
    end
    last_grant = g;
    cyc++;
  endtask

  task automatic read_streams(input int n_each, input int ps_from, input int ps_len);
    int cnt [2];
    int it;
    cnt[0] = n_each; cnt[1] = n_each; it = 0;
    while ((cnt[0] > 0 || cnt[1] > 0 || pv[0] || pv[1]) && it < 60) begin
      for (int i = 0; i < 2; i++)
        if (!pv[i] && cnt[i] > 0) begin
          set_req(i, 4'h0, 13'(16 + i * 8 + cnt[i]), 32'h0);
          cnt[i]--;
        end
      n_ps_en   = (it >= ps_from && it < ps_from + ps_len);
      n_ps_we   = 4'h0;
      n_ps_addr = 13'h0010;
      cycle();
      it++;
    end
    check_eq("stream_done", 32'(it < 60), 32'd1);
    n_ps_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; rr = 0; last_grant = -1;
    for (int i = 0; i < 8192; i++) begin
      mem_a[i] <= 32'h0; mem_b[i] <= 32'h0; ref_mem[i] = 32'h0;
    end
    for (int i = 0; i < NR; i++) begin
      pv[i] = 1'b0; pwe[i] = 4'h0; paddr[i] = '0; pdata[i] = '0;
    end
    n_rst = 1'b1; n_ps_en = 1'b0; n_ps_we = 4'h0; n_ps_addr = '0; n_ps_din = '0;
    rst = 1'b1; ps_en = 1'b0; ps_we = '0; ps_addr = '0; ps_din = '0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) cycle();
    n_rst = 1'b0;

    // PS write then read
    n_ps_en = 1'b1; n_ps_we = 4'hF; n_ps_addr = 13'h0010; n_ps_din = 32'hDEADBEEF;
    cycle();
    n_ps_we = 4'h0;
    cycle();
    n_ps_en = 1'b0;
    repeat (3) cycle();

    // single PL write then read on req0
    set_req(0, 4'hF, 13'h1FFF, 32'h12345678); cycle();
    set_req(0, 4'h0, 13'h1FFF, 32'h0);        cycle();
    repeat (3) cycle();

    // round-robin fairness, then PS preemption mid-stream
    read_streams(3, 99, 0);
    repeat (3) cycle();
    read_streams(4, 3, 3);
    repeat (3) cycle();

    // byte enables on req1
    set_req(1, 4'hF, 13'h0055, 32'hAABBCCDD);   cycle();
    set_req(1, 4'b0010, 13'h0055, 32'h00001100); cycle();
    set_req(1, 4'h0, 13'h0055, 32'h0);          cycle();
    repeat (3) cycle();

    // reset one cycle after a read is accepted
    set_req(0, 4'h0, 13'h1FFF, 32'h0); cycle();
    n_rst = 1'b1; cycle();
    n_rst = 1'b0;
    set_req(0, 4'h0, 13'h0055, 32'h0);
    set_req(1, 4'h0, 13'h0010, 32'h0);
    repeat (5) cycle();

    // randomized traffic
    for (int t = 0; t < 3000; t++) begin
      n_rst     = ($urandom_range(0, 99) == 0);
      n_ps_en   = ($urandom_range(0, 4) == 0);
      n_ps_we   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      n_ps_addr = 13'($urandom_range(0, 7));
      n_ps_din  = $urandom;
      for (int i = 0; i < NR; i++)
        if (!pv[i] && $urandom_range(0, 2) != 0)
          set_req(i, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                  13'($urandom_range(0, 7)), $urandom);
      cycle();
    end
    n_rst = 1'b0; n_ps_en = 1'b0;
    for (int i = 0; i < NR; i++) pv[i] = 1'b0;
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
